// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC sequencer with D-stage mispredict recovery
// Owns PCF, carries prediction metadata F->D, and raises redirect/flush on mispredict.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             PreBr,
    input  logic [31:0]      PCPredictF,
    input  logic             PCSrcD,
    input  logic             BrInstrD,
    input  logic [31:0]      PCBranchD,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic             PreBrD,
    output logic             MispredictD,
    output logic [31:0]      RedirectPC,
    output logic             FlushD,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [31:0]      pcf_q, pcf_d;
    logic             prebr_q, prebr_d;
    logic [31:0]      pred_target_q, pred_target_d;
    logic [31:0]      fall_through_q, fall_through_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic        resolve;
    logic        case_a, case_b, case_c;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pcf_q + 32'd4;
        resolve  = valid_q && BrInstrD && !StallD;
        case_a   = prebr_q && !PCSrcD;
        case_b   = !prebr_q && PCSrcD;
        case_c   = prebr_q && PCSrcD && (pred_target_q != PCBranchD);
        mispredict  = resolve && (case_a || case_b || case_c);
        // Only a predicted-taken branch that fell through recovers to the sequential PC.
        redirect_pc = (resolve && case_a) ? fall_through_q : PCBranchD;

        // A redirect beats StallF: whatever is stalled in F is on the wrong path.
        if (mispredict)      pcf_d = redirect_pc;
        else if (StallF)     pcf_d = pcf_q;
        else if (PreBr)      pcf_d = PCPredictF;
        else                 pcf_d = pc_plus4;

        if (mispredict) begin
            prebr_d        = 1'b0;
            pred_target_d  = 32'd0;
            fall_through_d = 32'd0;
            valid_d        = 1'b0;
        end else if (StallD) begin
            prebr_d        = prebr_q;
            pred_target_d  = pred_target_q;
            fall_through_d = fall_through_q;
            valid_d        = valid_q;
        end else begin
            prebr_d        = PreBr;
            pred_target_d  = PCPredictF;
            fall_through_d = pc_plus4;
            valid_d        = 1'b1;
        end

        br_cnt_d   = (resolve && br_cnt_q != CNT_MAX) ? br_cnt_q + CNT_ONE : br_cnt_q;
        miss_cnt_d = (mispredict && miss_cnt_q != CNT_MAX) ? miss_cnt_q + CNT_ONE : miss_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q          <= RESET_PC;
            prebr_q        <= 1'b0;
            pred_target_q  <= 32'd0;
            fall_through_q <= 32'd0;
            valid_q        <= 1'b0;
            br_cnt_q       <= '0;
            miss_cnt_q     <= '0;
        end else begin
            pcf_q          <= pcf_d;
            prebr_q        <= prebr_d;
            pred_target_q  <= pred_target_d;
            fall_through_q <= fall_through_d;
            valid_q        <= valid_d;
            br_cnt_q       <= br_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign PCF         = pcf_q;
    assign PCPlus4F    = pc_plus4;
    assign PreBrD      = prebr_q;
    assign MispredictD = mispredict;
    assign RedirectPC  = redirect_pc;
    assign FlushD      = mispredict;
    assign BrCount     = br_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC sequencer; consumes the branch predictor's F-stage outputs (PreBr, PCPredictF) and the D-stage branch resolution (PCSrcD, PCBranchD).
- Owns PCF, selects the next PC, carries prediction metadata F->D, detects mispredictions in D, and issues redirect and flush.
- Keeps saturating branch and mispredict counters for performance visibility.

Parameters:
RESET_PC, 32'h0000_0000, PCF value on reset
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hold PCF
StallD  in  1  hold F->D metadata registers
PreBr  in  1  predictor says the instruction at PCF is a taken branch
PCPredictF  in  32  predicted target for PCF
PCSrcD  in  1  branch in D resolved taken
BrInstrD  in  1  instruction in D is a conditional branch
PCBranchD  in  32  resolved branch target in D
PCF  out  32  current fetch PC
PCPlus4F  out  32  PCF+4
PreBrD  out  1  registered prediction for the instruction in D
MispredictD  out  1  redirect this cycle (combinational)
RedirectPC  out  32  recovery PC when MispredictD=1
FlushD  out  1  squash the F->D pipeline register (equals MispredictD)
BrCount  out  CNT_W  resolved conditional branches
MissCount  out  CNT_W  mispredictions

Behaviour:
- Reset (async, rst_n=0): PCF=RESET_PC; PreBrD=0; PredTargetD=0; FallThroughD=0; ValidD=0; BrCount=0; MissCount=0. Outputs become valid immediately, not at the next edge.
- PCPlus4F = PCF+32'd4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- F->D registers: PreBrD, PredTargetD (PCPredictF), FallThroughD (PCPlus4F), ValidD.
  - FlushD=1: clear them; ValidD=0.
  - Else StallD=1: hold.
  - Else: capture, with ValidD=1.
  - FlushD has priority over StallD.
- D resolution is evaluated only when ValidD && BrInstrD && !StallD ("resolve"):
  - Case A: PreBrD=1, PCSrcD=0 -> MispredictD=1, RedirectPC=FallThroughD.
  - Case B: PreBrD=0, PCSrcD=1 -> MispredictD=1, RedirectPC=PCBranchD.
  - Case C: PreBrD=1, PCSrcD=1, PredTargetD!=PCBranchD -> MispredictD=1, RedirectPC=PCBranchD.
  - Otherwise MispredictD=0 and RedirectPC=PCBranchD (don't-care).
- Next PCF, priority high to low:
  1. MispredictD -> RedirectPC. Overrides StallF: the wrong-path fetch is discarded.
  2. StallF -> hold.
  3. PreBr -> PCPredictF.
  4. Otherwise PCPlus4F.
- Flush latency: FlushD=MispredictD in the same cycle. The wrong-path instruction in F is squashed at the next edge, and the correct-path instruction appears at PCF one cycle after detection.
- Counters:
  - BrCount increments on every resolve.
  - MissCount increments on resolve && MispredictD.
  - Both saturate at all-ones and never wrap.
- Non-branch in D (BrInstrD=0) never mispredicts, even if PreBrD=1 (predictor aliasing). That case is accepted silently, with no count change.
- Reset mid-operation: all state returns to reset values on the same cycle. A pending redirect is dropped, and fetch restarts at RESET_PC.
- Simultaneous MispredictD and PreBr: the redirect wins; the PreBr of the wrong-path instruction is discarded with the flush.

Test Plan:
1. Reset and sequential fetch: rst_n low, then high, with no branches. PCF must read 0, 4, 8, 12 on successive edges; PreBrD=0; counters stay 0.
2. Correct taken prediction, PCF=0x10:
   - Stimulus: PreBr=1, PCPredictF=0x40. Next cycle: BrInstrD=1, PCSrcD=1, PCBranchD=0x40.
   - Required: PCF=0x40, then 0x44; MispredictD=0; FlushD=0; BrCount=1; MissCount=0.
3. Case A recovery, PCF=0x20:
   - Stimulus: PreBr=1, PCPredictF=0x80. Next cycle: PCSrcD=0.
   - Required: MispredictD=1; RedirectPC=0x24; FlushD=1. Next edge PCF=0x24 and ValidD=0. MissCount=1.
4. Case B and Case C:
   - Case B: PreBr=0 at 0x30, then PCSrcD=1, PCBranchD=0x100. Required: PCF=0x100 after flush.
   - Case C: predicted target 0x200, PCBranchD=0x208. Required: redirect to 0x208. MissCount increments for each case.
5. Stalls:
   - StallF=StallD=1 for 3 cycles. Required: PCF and PreBrD hold; no resolve occurs.
   - Redirect arriving while StallF=1 and StallD=0. Required: PCF still loads RedirectPC.
6. Saturation and reset mid-flight:
   - Force 2^CNT_W+2 mispredicts. Required: MissCount=16'hFFFF and it does not wrap.
   - Pulse rst_n low during a redirect cycle. Required: PCF=RESET_PC and both counters 0 immediately.
